// File: rtl/flash_boot_copier.sv
// flash_boot_copier
//   AHB-lite single-master boot copier. On a start pulse it reads WORD_COUNT
//   words from the flash window with single, non-pipelined NONSEQ transfers
//   and writes each one into boot SRAM. When the copy finishes it raises a
//   sticky done, or a sticky error if the bus returns an error.
//
//   Optional feature macro: BOOT_CHECKSUM_EN
//     When defined, the copier keeps a 32-bit additive sum of all copied
//     words. After the last SRAM write it reads one extra word at
//     SRC_BASE + 4*WORD_COUNT. That word is not written to SRAM. It is
//     compared against the sum: a match gives done, a mismatch gives error.
//     When undefined, done follows the final SRAM write directly.
//
//   Bus handshake: an address phase (HSELx=1, HTRANS=NONSEQ) is accepted
//   on the rising edge where HREADY=1. The following data phase completes
//   on the first rising edge where HREADY=1, and HRESP is only meaningful
//   on that edge. Every address-phase output holds steady until it is
//   accepted.
module flash_boot_copier #(
    parameter logic [31:0] SRC_BASE   = 32'h0000_0000,
    parameter int unsigned DST_BASE   = 0,
    parameter int unsigned WORD_COUNT = 256,
    parameter int unsigned SRAM_AW    = 10
) (
    input  logic               HCLK,
    input  logic               HRST,
    input  logic               start,
    output logic               HSELx,
    output logic [31:0]        HADDR,
    output logic [1:0]         HTRANS,
    output logic               HWRITE,
    output logic [1:0]         HSIZE,
    output logic [31:0]        HWDATA,
    input  logic [31:0]        HRDATA,
    input  logic               HREADY,
    input  logic [1:0]         HRESP,
    output logic               sram_we,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [31:0]        sram_wdata,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [2:0]         dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_DATA  = 3'd2,
        S_WR    = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5,
        S_CADDR = 3'd6,
        S_CDATA = 3'd7
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [15:0] LAST_CNT     = 16'(WORD_COUNT);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] haddr_q, haddr_d;
    logic [31:0] wdata_q, wdata_d;
    // Low for the first edge after reset release. This makes a start pulse
    // that coincides with reset deassertion get ignored.
    logic        armed_q;
    logic        start_ok;

`ifdef BOOT_CHECKSUM_EN
    logic [31:0] sum_q, sum_d;
`endif

    assign start_ok = start && armed_q;

    // State and datapath registers; asynchronous reset returns everything to idle values
    always_ff @(posedge HCLK or posedge HRST) begin
        if (HRST) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            haddr_q <= SRC_BASE;
            wdata_q <= 32'd0;
            armed_q <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            sum_q   <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            haddr_q <= haddr_d;
            wdata_q <= wdata_d;
            armed_q <= 1'b1;
`ifdef BOOT_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    // Next-state logic: one transfer in flight, ADDR -> DATA -> WR per word
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        haddr_d = haddr_q;
        wdata_d = wdata_q;
`ifdef BOOT_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            // Idle and both terminal states accept a new start. A new start
            // clears done/error by leaving those states.
            S_IDLE, S_DONE, S_ERR: begin
                if (start_ok) begin
                    state_d = S_ADDR;
                    cnt_d   = 16'd0;
                    haddr_d = SRC_BASE;
`ifdef BOOT_CHECKSUM_EN
                    sum_d   = 32'd0;
`endif
                end
            end
            // HRESP is ignored here. Only the data-phase response counts.
            S_ADDR: begin
                if (HREADY) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (HREADY) begin
                    if (HRESP != HRESP_OKAY) begin
                        state_d = S_ERR;
                    end else begin
                        wdata_d = HRDATA;
`ifdef BOOT_CHECKSUM_EN
                        sum_d   = sum_q + HRDATA;
`endif
                        state_d = S_WR;
                    end
                end
            end
            // The next read address is prepared here, so HADDR is already
            // stable on the first cycle of the next address phase. The
            // address wraps modulo 2^32.
            S_WR: begin
                cnt_d   = cnt_q + 16'd1;
                haddr_d = SRC_BASE + (32'(cnt_d) << 2);
                if (cnt_d == LAST_CNT) begin
`ifdef BOOT_CHECKSUM_EN
                    state_d = S_CADDR;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_ADDR;
                end
            end
`ifdef BOOT_CHECKSUM_EN
            S_CADDR: begin
                if (HREADY) begin
                    state_d = S_CDATA;
                end
            end
            // The checksum word is compared with the sum but never written to SRAM.
            S_CDATA: begin
                if (HREADY) begin
                    if ((HRESP != HRESP_OKAY) || (HRDATA != sum_q)) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus and status outputs decoded from the state register
    always_comb begin
        HSELx      = (state_q == S_ADDR) || (state_q == S_CADDR);
        HTRANS     = HSELx ? HTRANS_NONSEQ : HTRANS_IDLE;
        HADDR      = haddr_q;
        HWRITE     = 1'b0;
        HSIZE      = 2'b10;
        HWDATA     = 32'd0;
        sram_we    = (state_q == S_WR);
        sram_addr  = SRAM_AW'(DST_BASE) + SRAM_AW'(cnt_q);
        sram_wdata = wdata_q;
        busy       = (state_q == S_ADDR) || (state_q == S_DATA) || (state_q == S_WR) ||
                     (state_q == S_CADDR) || (state_q == S_CDATA);
        done       = (state_q == S_DONE);
        error      = (state_q == S_ERR);
        dbg_state  = state_q;
    end

endmodule

// File: tb/tb_flash_boot_copier.sv
// tb_flash_boot_copier
//   Directed bench for flash_boot_copier with WORD_COUNT=4, SRC_BASE=0 and
//   DST_BASE=0. A behavioural AHB slave serves words from a small array.
//   It supports per-word wait states and error injection. The expected SRAM
//   writes (cycle, address, data) and the expected bus addresses are queued
//   when each copy is issued. A negedge monitor pops and compares them
//   whenever the DUT presents a write or an address phase.
`timescale 1ns/1ps
module tb_flash_boot_copier;
    localparam int WC = 4;
    localparam int AW = 10;
    localparam int EW = 32 + AW + 32;
`ifdef BOOT_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic          HCLK, HRST, start;
    logic          HSELx, HWRITE, HREADY, sram_we, busy, done, error;
    logic [31:0]   HADDR, HWDATA, HRDATA, sram_wdata;
    logic [1:0]    HTRANS, HSIZE, HRESP;
    logic [AW-1:0] sram_addr;
    logic [2:0]    dbg_state;

    flash_boot_copier #(
        .SRC_BASE(32'h0000_0000), .DST_BASE(0), .WORD_COUNT(WC), .SRAM_AW(AW)
    ) dut (
        .HCLK(HCLK), .HRST(HRST), .start(start),
        .HSELx(HSELx), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY),
        .HRESP(HRESP), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .busy(busy), .done(done), .error(error),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int cyc = 0;
    initial forever begin
        @(posedge HCLK);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got cyc=%0d", cyc);
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    logic [31:0]   exp_a_q[$];
    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- flash slave model ----------------
    logic [31:0] mem[0:7];
    int  wait_tbl[0:7];
    int  err_word = -1;
    bit  addr_err = 0;

    initial begin
        bit pend, in_data;
        int pend_idx, dp_idx, waits;
        pend = 0; in_data = 0; pend_idx = 0; dp_idx = 0; waits = 0;
        HREADY = 1'b1; HRESP = 2'b00; HRDATA = 32'd0;
        forever begin
            @(posedge HCLK);
            #1;
            if (HRST) begin
                pend = 0; in_data = 0;
                HREADY = 1'b1; HRESP = 2'b00; HRDATA = 32'd0;
            end else begin
                if (pend) begin
                    in_data = 1; dp_idx = pend_idx; waits = wait_tbl[pend_idx]; pend = 0;
                end
                if (in_data) begin
                    if (waits > 0) begin
                        HREADY = 1'b0; HRESP = 2'b00; HRDATA = 32'hDEAD_BEEF; waits--;
                    end else begin
                        HREADY = 1'b1; HRDATA = mem[dp_idx];
                        HRESP  = (dp_idx == err_word) ? 2'b01 : 2'b00;
                        in_data = 0;
                    end
                end else begin
                    HREADY = 1'b1; HRDATA = 32'hDEAD_BEEF;
                    HRESP  = (addr_err && HSELx) ? 2'b01 : 2'b00;
                end
                if (HSELx && HTRANS == 2'b10 && HREADY) begin
                    pend = 1; pend_idx = int'(HADDR[4:2]);
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial forever begin
        @(negedge HCLK);
        if (!HRST) begin
            if (sram_we) begin
                if (exp_q.size() == 0) chk("sram_write_unexpected", {32'(cyc), sram_addr, sram_wdata}, '0);
                else chk("sram_write", {32'(cyc), sram_addr, sram_wdata}, exp_q.pop_front());
            end
            if (HSELx && HTRANS == 2'b10 && HREADY) begin
                if (exp_a_q.size() == 0) chk("haddr_unexpected", HADDR, 32'hFFFF_FFFF);
                else chk("haddr", HADDR, exp_a_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic load_mem(input logic [31:0] base);
        logic [31:0] s;
        s = 32'd0;
        for (int i = 0; i < 8; i++) mem[i] = base + 32'(i);
        for (int i = 0; i < WC; i++) s = s + mem[i];
        if (CK == 1) mem[WC] = s;
    endtask

    // The word k write lands 3 cycles after the previous one, plus that
    // word's wait states. Cycle c0 is the cycle in which start is driven.
    task automatic push_exp(input int c0, input int n_wr, input int n_addr);
        int t;
        t = c0;
        for (int k = 0; k < n_wr; k++) begin
            t = t + 3 + wait_tbl[k];
            exp_q.push_back({32'(t), AW'(k), mem[k]});
        end
        for (int k = 0; k < n_addr; k++) exp_a_q.push_back(32'(4 * k));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget, output int c_end);
        int n;
        n = 0;
        while (!(done || error) && n < budget) begin
            tick();
            n++;
        end
        if (!(done || error)) chk("wait_end_timeout", 0, 1);
        c_end = cyc;
    endtask

    task automatic chk_queues(input string name);
        chk({name, "_wr_q_empty"}, exp_q.size(), 0);
        chk({name, "_addr_q_empty"}, exp_a_q.size(), 0);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int c0, ce;
        for (int i = 0; i < 8; i++) wait_tbl[i] = 0;
        start = 1'b0;
        HRST  = 1'b1;
        repeat (3) tick();

        // Reset values
        chk("rst_hselx", HSELx, 0);
        chk("rst_htrans", HTRANS, 0);
        chk("rst_haddr", HADDR, 0);
        chk("rst_sram_we", sram_we, 0);
        chk("rst_sram_addr", sram_addr, 0);
        chk("rst_sram_wdata", sram_wdata, 0);
        chk("rst_status", {busy, done, error}, 0);
        chk("rst_static", {HWRITE, HSIZE, HWDATA}, {1'b0, 2'b10, 32'd0});
        HRST = 1'b0;
        repeat (2) tick();

        // T1: zero-wait copy of A0..A3, done visible 13 cycles after start
        load_mem(32'h0000_00A0);
        c0 = cyc;
        push_exp(c0, WC, WC + CK);
        pulse_start();
        chk("t1_busy", busy, 1);
        wait_end(200, ce);
        chk("t1_done_cycle", ce, c0 + 13 + 2 * CK);
        chk("t1_status", {busy, done, error}, 3'b010);
        chk_queues("t1");

        // T2: five wait states on word 2 delay writes 2 and 3 by five cycles
        load_mem(32'hB000_0000);
        wait_tbl[2] = 5;
        c0 = cyc;
        push_exp(c0, WC, WC + CK);
        pulse_start();
        wait_end(200, ce);
        chk("t2_done_cycle", ce, c0 + 18 + 2 * CK);
        chk("t2_status", {busy, done, error}, 3'b010);
        chk_queues("t2");
        wait_tbl[2] = 0;

        // T3: data-phase error on word 1, exactly one SRAM write
        load_mem(32'hC000_00C0);
        err_word = 1;
        c0 = cyc;
        push_exp(c0, 1, 2);
        pulse_start();
        wait_end(200, ce);
        chk("t3_err_cycle", ce, c0 + 6);
        chk("t3_status", {busy, done, error}, 3'b001);
        chk_queues("t3");
        err_word = -1;

        // T4: error response during address phases is ignored
        load_mem(32'hD000_00D0);
        addr_err = 1;
        c0 = cyc;
        push_exp(c0, WC, WC + CK);
        pulse_start();
        wait_end(200, ce);
        chk("t4_done_cycle", ce, c0 + 13 + 2 * CK);
        chk("t4_status", {busy, done, error}, 3'b010);
        chk_queues("t4");
        addr_err = 0;

        // T5: reset during the data phase of word 3, then a fresh copy
        load_mem(32'hE000_00E0);
        wait_tbl[3] = 4;
        c0 = cyc;
        push_exp(c0, 3, 4);
        pulse_start();
        while (cyc < c0 + 12) tick();
        chk("t5_in_data", dbg_state, 3'd2);
        HRST = 1'b1;
        #1;
        chk("t5_rst_state", dbg_state, 0);
        chk("t5_rst_bus", {HSELx, HTRANS, HADDR}, 0);
        chk("t5_rst_sram", {sram_we, sram_addr, sram_wdata}, 0);
        chk("t5_rst_status", {busy, done, error}, 0);
        repeat (2) tick();
        chk_queues("t5");
        wait_tbl[3] = 0;
        HRST  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("t5_start_at_release_ignored", {busy, done, error}, 0);
        load_mem(32'hF000_00F0);
        c0 = cyc;
        push_exp(c0, WC, WC + CK);
        pulse_start();
        wait_end(200, ce);
        chk("t5_done_cycle", ce, c0 + 13 + 2 * CK);
        chk_queues("t5b");

        // T6: start during busy is ignored; start after done runs a second copy
        load_mem(32'h1111_0000);
        c0 = cyc;
        push_exp(c0, WC, WC + CK);
        pulse_start();
        repeat (2) tick();
        pulse_start();
        wait_end(200, ce);
        chk("t6_done_cycle", ce, c0 + 13 + 2 * CK);
        chk_queues("t6");
        load_mem(32'h2222_0000);
        c0 = cyc;
        push_exp(c0, WC, WC + CK);
        pulse_start();
        chk("t6_restart_clears_done", {busy, done, error}, 3'b100);
        wait_end(200, ce);
        chk("t6_second_done_cycle", ce, c0 + 13 + 2 * CK);
        chk("t6_second_status", {busy, done, error}, 3'b010);
        chk_queues("t6b");

`ifdef BOOT_CHECKSUM_EN
        // T7: checksum words 1..4; check word 10 passes, 11 fails
        for (int i = 0; i < WC; i++) mem[i] = 32'(i + 1);
        mem[WC] = 32'd10;
        c0 = cyc;
        push_exp(c0, WC, WC + 1);
        pulse_start();
        wait_end(200, ce);
        chk("t7_sum_ok_cycle", ce, c0 + 15);
        chk("t7_sum_ok_status", {busy, done, error}, 3'b010);
        chk_queues("t7");
        mem[WC] = 32'd11;
        c0 = cyc;
        push_exp(c0, WC, WC + 1);
        pulse_start();
        wait_end(200, ce);
        chk("t7_sum_bad_cycle", ce, c0 + 15);
        chk("t7_sum_bad_status", {busy, done, error}, 3'b001);
        chk_queues("t7b");
`endif

        repeat (3) tick();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
